// File: rtl/line_engine.sv
// line_engine: Bresenham line rasteriser emitting one framebuffer pixel write per handshake.
// Endpoints and color are loaded while idle; a trigger runs SETUP for one cycle, then DRAW.
module line_engine #(
    parameter logic [31:0] FB_BASE = 32'h1080_0000,
    parameter int          CW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   line_color,
    input  logic [CW-1:0] line_point,
    input  logic          line_color_valid,
    input  logic          line_x0_valid,
    input  logic          line_y0_valid,
    input  logic          line_x1_valid,
    input  logic          line_y1_valid,
    input  logic          line_trigger,
    output logic          line_ready,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [31:0]   px_addr,
    output logic [31:0]   px_color
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, DRAW = 2'd2;
    logic [1:0]           state_q, state_d;
    logic [31:0]          color_q;
    logic [CW-1:0]        x0_q, y0_q, x1_q, y1_q, cx_q, cy_q, ex_q;
    logic [CW:0]          dx_q, dy_q;
    logic signed [CW+1:0] err_q, err_nx;
    logic                 steep_q, up_q;
    logic [CW-1:0]        adx, ady, ax0, ay0, ax1, ay1, sx0, sy0, sx1, sy1, px, py;
    logic                 steep, swap, last;
    always_comb begin
        adx    = (x1_q > x0_q) ? x1_q - x0_q : x0_q - x1_q;
        ady    = (y1_q > y0_q) ? y1_q - y0_q : y0_q - y1_q;
        steep  = ady > adx;
        ax0    = steep ? y0_q : x0_q;
        ay0    = steep ? x0_q : y0_q;
        ax1    = steep ? y1_q : x1_q;
        ay1    = steep ? x1_q : y1_q;
        swap   = ax0 > ax1;
        sx0    = swap ? ax1 : ax0;
        sy0    = swap ? ay1 : ay0;
        sx1    = swap ? ax0 : ax1;
        sy1    = swap ? ay0 : ay1;
        last   = cx_q == ex_q;
        err_nx = err_q - $signed({1'b0, dy_q});
        px     = steep_q ? cy_q : cx_q;
        py     = steep_q ? cx_q : cy_q;
        state_d = state_q == IDLE  ? (line_trigger ? SETUP : IDLE) :
                  state_q == SETUP ? DRAW :
                  state_q == DRAW  ? ((px_ready && last) ? IDLE : DRAW) : IDLE;
    end
    assign line_ready = state_q == IDLE;
    assign px_valid   = state_q == DRAW;
    assign px_addr    = px_valid ? FB_BASE + 32'({py, px, 2'b00}) : 32'd0;
    assign px_color   = px_valid ? color_q : 32'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            color_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            ex_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            steep_q <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (line_color_valid) color_q <= line_color;
                if (line_x0_valid) x0_q <= line_point;
                if (line_y0_valid) y0_q <= line_point;
                if (line_x1_valid) x1_q <= line_point;
                if (line_y1_valid) y1_q <= line_point;
            end
            if (state_q == SETUP) begin
                steep_q <= steep;
                cx_q    <= sx0;
                cy_q    <= sy0;
                ex_q    <= sx1;
                up_q    <= sy0 < sy1;
                dx_q    <= {1'b0, sx1 - sx0};
                dy_q    <= {1'b0, (sy1 > sy0) ? sy1 - sy0 : sy0 - sy1};
                err_q   <= $signed({2'b00, sx1 - sx0}) >>> 1;
            end
            // Step along the major axis; minor axis moves when the error goes negative.
            if (state_q == DRAW && px_ready && !last) begin
                cx_q  <= cx_q + 1'b1;
                err_q <= err_nx < 0 ? err_nx + $signed({1'b0, dx_q}) : err_nx;
                if (err_nx < 0) cy_q <= up_q ? cy_q + 1'b1 : cy_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: scoreboard bench; expected pixel writes are queued as lines are issued
// and popped by a monitor on every accepted handshake.
module tb_line_engine;
    localparam logic [31:0] FB_BASE = 32'h1080_0000;
    logic        clk = 0, rst = 1;
    logic [31:0] line_color = 0;
    logic [9:0]  line_point = 0;
    logic        line_color_valid = 0, line_x0_valid = 0, line_y0_valid = 0;
    logic        line_x1_valid = 0, line_y1_valid = 0, line_trigger = 0;
    logic        line_ready, px_valid, px_ready = 1;
    logic [31:0] px_addr, px_color;
    logic [63:0] exp_q[$];
    int          n_vec = 0, n_err = 0, npx = 0;

    line_engine #(.FB_BASE(FB_BASE), .CW(10)) dut (
        .clk(clk), .rst(rst), .line_color(line_color), .line_point(line_point),
        .line_color_valid(line_color_valid), .line_x0_valid(line_x0_valid),
        .line_y0_valid(line_y0_valid), .line_x1_valid(line_x1_valid),
        .line_y1_valid(line_y1_valid), .line_trigger(line_trigger),
        .line_ready(line_ready), .px_valid(px_valid), .px_ready(px_ready),
        .px_addr(px_addr), .px_color(px_color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fb(input int x, input int y);
        return FB_BASE + ((y * 1024 + x) * 4);
    endfunction

    task automatic push(input int x, input int y, input logic [31:0] c);
        exp_q.push_back({fb(x, y), c});
    endtask

    always @(negedge clk) begin
        if (!rst && px_valid && px_ready) begin
            npx++;
            if (exp_q.size() == 0) check("extra_pixel", {px_addr, px_color}, 64'd0);
            else check("pixel", {px_addr, px_color}, exp_q.pop_front());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ld(input logic [4:0] sel, input logic [9:0] v, input logic [31:0] c);
        {line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid} = sel;
        line_point = v;
        line_color = c;
        step();
        {line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid} = 5'b0;
    endtask

    task automatic load(input int x0, input int y0, input int x1, input int y1, input logic [31:0] c);
        ld(5'b10000, 10'd0, c);
        ld(5'b01000, 10'(x0), 32'd0);
        ld(5'b00100, 10'(y0), 32'd0);
        ld(5'b00010, 10'(x1), 32'd0);
        ld(5'b00001, 10'(y1), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int start, input int n);
        int k = 0;
        while (!line_ready && k < 300) begin
            step();
            k++;
        end
        check({tag, "_done"}, 64'(line_ready), 64'd1);
        check({tag, "_count"}, 64'(npx - start), 64'(n));
        check({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run(input string tag, input int n);
        int start = npx;
        line_trigger = 1;
        step();
        line_trigger = 0;
        check({tag, "_busy"}, 64'(line_ready), 64'd0);
        wait_idle(tag, start, n);
    endtask

    initial begin
        logic [31:0] ha, hc;
        int          start, k, nv;
        step(3);
        check("rst_ready", 64'(line_ready), 64'd1);
        check("rst_valid", 64'(px_valid), 64'd0);
        check("rst_addr", 64'(px_addr), 64'd0);
        check("rst_color", 64'(px_color), 64'd0);
        rst = 0;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            nv += int'(px_valid);
        end
        check("idle_quiet", 64'(nv), 64'd0);

        load(0, 0, 3, 0, 32'h00FF00FF);
        for (int x = 0; x < 4; x++) push(x, 0, 32'h00FF00FF);
        run("horiz", 4);

        load(5, 0, 6, 3, 32'hA5A5_0001);
        push(5, 0, 32'hA5A5_0001); push(5, 1, 32'hA5A5_0001);
        push(6, 2, 32'hA5A5_0001); push(6, 3, 32'hA5A5_0001);
        run("steep", 4);
        load(6, 3, 5, 0, 32'hA5A5_0002);
        push(5, 0, 32'hA5A5_0002); push(5, 1, 32'hA5A5_0002);
        push(6, 2, 32'hA5A5_0002); push(6, 3, 32'hA5A5_0002);
        run("steep_rev", 4);

        load(0, 0, 4, 2, 32'h1234_5678);
        push(0, 0, 32'h1234_5678); push(1, 0, 32'h1234_5678); push(2, 1, 32'h1234_5678);
        push(3, 1, 32'h1234_5678); push(4, 2, 32'h1234_5678);
        run("shallow", 5);
        load(4, 0, 0, 2, 32'h0BAD_F00D);
        push(0, 2, 32'h0BAD_F00D); push(1, 2, 32'h0BAD_F00D); push(2, 1, 32'h0BAD_F00D);
        push(3, 1, 32'h0BAD_F00D); push(4, 0, 32'h0BAD_F00D);
        run("ydown", 5);

        load(7, 9, 7, 9, 32'hCAFE_BABE);
        push(7, 9, 32'hCAFE_BABE);
        run("point", 1);

        load(0, 1, 4, 1, 32'h7777_0000);
        for (int x = 0; x < 5; x++) push(x, 1, 32'h7777_0000);
        start = npx;
        line_trigger = 1;
        step();
        line_trigger = 0;
        k = 0;
        while (!px_valid && k < 10) begin
            step();
            k++;
        end
        check("bp_first", 64'(px_valid), 64'd1);
        step();
        px_ready = 0;
        ha = px_addr;
        hc = px_color;
        check("bp_second", 64'(ha), 64'(fb(1, 1)));
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", {31'd0, px_valid, ha, hc}, {31'd0, 1'b1, px_addr, px_color});
        end
        px_ready = 1;
        wait_idle("bp", start, 5);

        load(0, 2, 2, 2, 32'h0000_BEEF);
        for (int x = 0; x < 3; x++) push(x, 2, 32'h0000_BEEF);
        start = npx;
        line_trigger = 1;
        step();
        line_trigger = 0;
        ld(5'b01000, 10'd1, 32'd0);
        line_trigger = 1;
        step();
        line_trigger = 0;
        wait_idle("busy_strobe", start, 3);
        for (int x = 0; x < 3; x++) push(x, 2, 32'h0000_BEEF);
        run("retrig", 3);

        load(0, 0, 9, 0, 32'h5555_AAAA);
        for (int x = 0; x < 10; x++) push(x, 0, 32'h5555_AAAA);
        line_trigger = 1;
        step();
        line_trigger = 0;
        step(3);
        check("mid_valid", 64'(px_valid), 64'd1);
        rst = 1;
        step();
        check("abort_valid", 64'(px_valid), 64'd0);
        check("abort_ready", 64'(line_ready), 64'd1);
        check("abort_addr", 64'(px_addr), 64'd0);
        rst = 0;
        exp_q.delete();
        push(0, 0, 32'd0);
        run("cleared", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
